pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline. It sits beside the ID-stage control decoder.
- Detects load-use hazards in ID and squashes wrong-path instructions on EX-resolved redirects (taken branch, JAL, JALR).
- Sequences the multi-cycle M-extension unit in EX by freezing the front end until that unit signals done.
- Keeps saturating performance counters for stall cycles and redirects.

Parameters:
- MD_TIMEOUT, 64: maximum number of MD_BUSY cycles before a forced release.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_opcode  in  7  opcode of the instruction in IF/ID
- id_rs1  in  5  rs1 field in IF/ID
- id_rs2  in  5  rs2 field in IF/ID
- ex_rd  in  5  rd of the instruction in ID/EX
- ex_memread  in  1  instruction in EX is a load
- ex_redirect  in  1  taken branch or jump resolved in EX
- ex_is_muldiv  in  1  instruction in EX is MUL/DIV/REM
- md_done  in  1  multi-cycle unit result valid (single-cycle pulse)
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID register enable
- id_ex_en  out  1  ID/EX register enable
- if_id_flush  out  1  clear IF/ID to a NOP
- id_ex_flush  out  1  clear ID/EX to a bubble (all control bits 0)
- ex_mem_bubble  out  1  write a bubble into EX/MEM
- md_start  out  1  start pulse to the multi-cycle unit
- md_timeout  out  1  sticky error flag
- stall_cnt  out  CNT_W  cycles with pc_en=0
- redirect_cnt  out  CNT_W  number of redirects taken

Behaviour:
- FSM states: RUN, MD_BUSY. Reset state is RUN.
- Registered state: FSM state, timeout counter, md_timeout, stall_cnt, redirect_cnt. All other outputs are combinational from state and inputs.
- During rst=1:
  - pc_en=0, if_id_en=0, id_ex_en=0.
  - if_id_flush=1, id_ex_flush=1.
  - ex_mem_bubble=1, md_start=0.
  - Counters are cleared; md_timeout=0. Reset mid-MD_BUSY returns to RUN.
- Default outputs, with no condition active: all enables 1, all flushes 0, ex_mem_bubble=0, md_start=0.
- Register-read decode from id_opcode:
  - rs1 is used for opcodes 51, 19, 3, 35, 103, 99.
  - rs2 is used for opcodes 51, 35, 99.
  - Any other opcode reads no registers.
- Load-use hazard = ex_memread && ex_rd!=0 && ((rs1 used && id_rs1==ex_rd) || (rs2 used && id_rs2==ex_rd)).
- Priority in RUN is redirect > muldiv > load-use:
  - ex_redirect=1:
    - pc_en=1; the PC loads the target.
    - if_id_flush=1, id_ex_flush=1.
    - redirect_cnt increments.
    - Any load-use hazard or muldiv in the same cycle is ignored; the ID instruction is squashed. A redirect and a muldiv cannot be in EX together by construction.
  - ex_is_muldiv=1:
    - md_start=1.
    - pc_en=0, if_id_en=0, id_ex_en=0.
    - ex_mem_bubble=1.
    - Next state MD_BUSY; the timeout counter is cleared.
  - Load-use hazard: pc_en=0, if_id_en=0, id_ex_flush=1 for exactly 1 cycle. On the following cycle the load has left EX and the hazard clears naturally.
- MD_BUSY:
  - md_done=0:
    - pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_bubble=1.
    - The timeout counter increments.
  - md_done=1 (release):
    - Default outputs; the EX result enters EX/MEM.
    - Next state RUN.
    - ex_is_muldiv is still high this cycle and must not re-trigger md_start.
  - Timeout counter reaches MD_TIMEOUT-1 with md_done=0:
    - md_timeout is set (sticky until rst).
    - The release cycle has ex_mem_bubble=1, so the instruction is dropped.
    - Next state RUN.
  - md_done in RUN is ignored.
  - Load-use detection is suppressed in MD_BUSY because the front end is already frozen.
- Latency:
  - md_start is asserted in the same cycle the muldiv enters EX.
  - The minimum muldiv occupancy is 2 cycles (start cycle plus done cycle).
- Counters:
  - stall_cnt increments on every non-reset cycle with pc_en=0.
  - Both counters saturate at all-ones and do not wrap.

Decomposition:
- Shared package `riscv_pkg` holds:
  - the opcode localparams: OP_R=51, OP_I=19, OP_LOAD=3, OP_STORE=35, OP_JAL=111, OP_JALR=103, OP_BRANCH=99, OP_LUI=55, OP_AUIPC=23;
  - typedef enum `md_state_t` {RUN, MD_BUSY}.
- One natural sub-module: `sat_counter` (parameterised CNT_W, inputs inc and clr), instantiated twice.
- Hazard compare logic stays inline.

Test Plan:
1. lw x5 in EX (ex_rd=5, ex_memread=1); ID add x6,x5,x7 (opcode 51, id_rs1=5) -> one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1.
2. Same as scenario 1 but ex_rd=0, or ID is lui (opcode 55) with id_rs1=5 -> no stall; all defaults.
3. ex_redirect=1 together with a load-use hazard -> if_id_flush=1, id_ex_flush=1, pc_en=1, no stall; redirect_cnt=1.
4. ex_is_muldiv=1, md_done arrives 4 cycles after md_start -> md_start high for 1 cycle; pc_en=0 for 4 cycles; release on the done cycle with ex_mem_bubble=0; stall_cnt=4; no second md_start.
5. MD_TIMEOUT=8, md_done never asserted -> forced release on the 8th busy cycle with ex_mem_bubble=1; md_timeout=1 held; state returns to RUN.
6. rst pulsed during MD_BUSY cycle 2 -> next cycle state=RUN, counters=0, md_timeout=0; later md_done is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: base opcodes, hazard-controller FSM states,
// and the register-read decode used by the ID-stage hazard check.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_I      = 7'd19;
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_JAL    = 7'd111;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_AUIPC  = 7'd23;

  typedef enum logic {RUN, MD_BUSY} md_state_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_JALR, OP_BRANCH};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP_R, OP_STORE, OP_BRANCH};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use stalls, redirect
// squashes, multi-cycle MUL/DIV freeze with timeout, and saturating perf counters.
module pipeline_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             ex_is_muldiv,
  input  logic             md_done,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             md_start,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam int              TO_W    = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

  md_state_t       state, state_next;
  logic [TO_W-1:0] to_cnt;
  logic            to_clr, to_inc, to_fire, redirect_inc;
  logic            load_use;

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((uses_rs1(id_opcode) && (id_rs1 == ex_rd)) ||
                     (uses_rs2(id_opcode) && (id_rs2 == ex_rd)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    md_start      = 1'b0;
    state_next    = state;
    to_clr        = 1'b0;
    to_inc        = 1'b0;
    to_fire       = 1'b0;
    redirect_inc  = 1'b0;

    if (rst) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_bubble = 1'b1;
      state_next    = RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            redirect_inc = 1'b1;
          end else if (ex_is_muldiv) begin
            md_start      = 1'b1;
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
            to_clr        = 1'b1;
            state_next    = MD_BUSY;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        MD_BUSY: begin
          // A real done outranks a timeout landing on the same cycle.
          if (md_done) begin
            state_next = RUN;
          end else if (to_cnt == TO_LAST) begin
            to_fire       = 1'b1;
            ex_mem_bubble = 1'b1;
            state_next    = RUN;
          end else begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
            to_inc        = 1'b1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      to_cnt     <= '0;
      md_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (to_clr) begin
        to_cnt <= '0;
      end else if (to_inc) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (to_fire) begin
        md_timeout <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (!pc_en),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .clr   (rst),
    .inc   (redirect_inc),
    .count (redirect_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations, then random traffic checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int MD_TIMEOUT = 8;
  localparam int CNT_W      = 5;
  localparam int SAT        = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             ex_memread, ex_redirect, ex_is_muldiv, md_done;
  logic             pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush;
  logic             ex_mem_bubble, md_start, md_timeout;
  logic [CNT_W-1:0] stall_cnt, redirect_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  pipeline_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_opcode     (id_opcode),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_rd         (ex_rd),
    .ex_memread    (ex_memread),
    .ex_redirect   (ex_redirect),
    .ex_is_muldiv  (ex_is_muldiv),
    .md_done       (md_done),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_bubble (ex_mem_bubble),
    .md_start      (md_start),
    .md_timeout    (md_timeout),
    .stall_cnt     (stall_cnt),
    .redirect_cnt  (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: the multi-cycle unit is tracked as "busy for N cycles so far";
  // the front end is frozen until done or until MD_TIMEOUT busy cycles have elapsed.
  bit m_busy   = 1'b0;
  int m_busy_n = 0;
  bit m_tout   = 1'b0;
  int m_stall  = 0;
  int m_redir  = 0;

  always @(negedge clk) begin
    bit e_pc, e_ifid, e_idex, e_iff, e_idf, e_bub, e_start, hazard;
    e_pc = 1; e_ifid = 1; e_idex = 1; e_iff = 0; e_idf = 0; e_bub = 0; e_start = 0;
    hazard = ex_memread && ex_rd != 0 &&
             ((id_opcode inside {51, 19, 3, 35, 103, 99} && id_rs1 == ex_rd) ||
              (id_opcode inside {51, 35, 99} && id_rs2 == ex_rd));

    check("stall_cnt", stall_cnt, m_stall);
    check("redirect_cnt", redirect_cnt, m_redir);
    check("md_timeout", md_timeout, m_tout);

    if (rst) begin
      {e_pc, e_ifid, e_idex} = 3'b000;
      {e_iff, e_idf, e_bub}  = 3'b111;
      m_busy = 0; m_busy_n = 0; m_tout = 0; m_stall = 0; m_redir = 0;
    end else begin
      if (!m_busy) begin
        if (ex_redirect) begin
          e_iff = 1; e_idf = 1;
          if (m_redir < SAT) m_redir++;
        end else if (ex_is_muldiv) begin
          e_start = 1; e_pc = 0; e_ifid = 0; e_idex = 0; e_bub = 1;
          m_busy = 1; m_busy_n = 0;
        end else if (hazard) begin
          e_pc = 0; e_ifid = 0; e_idf = 1;
        end
      end else if (md_done) begin
        m_busy = 0;
      end else if (m_busy_n + 1 == MD_TIMEOUT) begin
        e_bub = 1; m_tout = 1; m_busy = 0;
      end else begin
        e_pc = 0; e_ifid = 0; e_idex = 0; e_bub = 1;
        m_busy_n++;
      end
      if (!e_pc && m_stall < SAT) m_stall++;
    end

    check("pc_en", pc_en, e_pc);
    check("if_id_en", if_id_en, e_ifid);
    check("id_ex_en", id_ex_en, e_idex);
    check("if_id_flush", if_id_flush, e_iff);
    check("id_ex_flush", id_ex_flush, e_idf);
    check("ex_mem_bubble", ex_mem_bubble, e_bub);
    check("md_start", md_start, e_start);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; id_opcode = 7'd19; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    ex_memread = 0; ex_redirect = 0; ex_is_muldiv = 0; md_done = 0;
  endtask

  initial begin
    logic [6:0] ops [10];
    ops = '{7'd51, 7'd19, 7'd3, 7'd35, 7'd111, 7'd103, 7'd99, 7'd55, 7'd23, 7'd0};
    idle();
    rst = 1;

    // Reset outputs.
    tick(); settle();
    check("rst_pc_en", pc_en, 0);
    check("rst_if_id_flush", if_id_flush, 1);
    check("rst_ex_mem_bubble", ex_mem_bubble, 1);
    check("rst_md_start", md_start, 0);

    // 1: lw x5 in EX, add x6,x5,x7 in ID.
    tick(); idle(); ex_rd = 5; ex_memread = 1; id_opcode = 7'd51; id_rs1 = 5; id_rs2 = 7;
    settle();
    check("lu_pc_en", pc_en, 0);
    check("lu_if_id_en", if_id_en, 0);
    check("lu_id_ex_flush", id_ex_flush, 1);
    check("lu_stall_cnt0", stall_cnt, 0);
    tick(); idle(); settle();
    check("lu_after_pc_en", pc_en, 1);
    check("lu_stall_cnt1", stall_cnt, 1);

    // 2: rd=x0, and lui reading no registers.
    tick(); idle(); ex_memread = 1; id_opcode = 7'd51; settle();
    check("x0_pc_en", pc_en, 1);
    tick(); idle(); ex_memread = 1; ex_rd = 5; id_opcode = 7'd55; id_rs1 = 5; settle();
    check("lui_pc_en", pc_en, 1);
    check("lui_id_ex_flush", id_ex_flush, 0);

    // 3: redirect overrides a simultaneous load-use hazard.
    tick(); idle(); ex_memread = 1; ex_rd = 5; id_opcode = 7'd51; id_rs1 = 5; ex_redirect = 1;
    settle();
    check("redir_pc_en", pc_en, 1);
    check("redir_if_id_flush", if_id_flush, 1);
    check("redir_id_ex_flush", id_ex_flush, 1);
    tick(); idle(); settle();
    check("redir_cnt", redirect_cnt, 1);
    check("redir_stall_cnt", stall_cnt, 1);

    // 4: muldiv with done 4 cycles after start.
    tick(); idle(); rst = 1;
    tick(); idle(); ex_is_muldiv = 1; settle();
    check("md_start_pulse", md_start, 1);
    check("md_start_pc_en", pc_en, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(); settle();
      check("md_busy_start", md_start, 0);
      check("md_busy_pc_en", pc_en, 0);
    end
    tick(); md_done = 1; settle();
    check("md_done_pc_en", pc_en, 1);
    check("md_done_bubble", ex_mem_bubble, 0);
    check("md_done_start", md_start, 0);
    tick(); idle(); settle();
    check("md_stall_cnt", stall_cnt, 4);

    // 5: timeout with md_done never asserted.
    tick(); idle(); rst = 1;
    tick(); idle(); ex_is_muldiv = 1;
    for (int i = 1; i <= 7; i++) begin
      tick(); settle();
      check("to_busy_pc_en", pc_en, 0);
    end
    tick(); settle();
    check("to_release_bubble", ex_mem_bubble, 1);
    check("to_release_pc_en", pc_en, 1);
    check("to_release_start", md_start, 0);
    tick(); idle(); settle();
    check("to_flag", md_timeout, 1);
    check("to_stall_cnt", stall_cnt, 8);
    tick(); settle();
    check("to_flag_sticky", md_timeout, 1);

    // 6: reset during the second busy cycle, stray md_done afterwards.
    tick(); idle(); rst = 1;
    tick(); idle(); ex_is_muldiv = 1;
    tick();
    tick(); rst = 1; settle();
    check("rst_busy_pc_en", pc_en, 0);
    tick(); idle(); md_done = 1; settle();
    check("post_rst_pc_en", pc_en, 1);
    check("post_rst_bubble", ex_mem_bubble, 0);
    check("post_rst_stall_cnt", stall_cnt, 0);
    check("post_rst_timeout", md_timeout, 0);

    // Random traffic; narrow register ranges keep hazards frequent.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst          = ($urandom_range(0, 149) == 0);
      id_opcode    = ops[$urandom_range(0, 9)];
      if (id_opcode == 7'd0) id_opcode = 7'($urandom);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      ex_memread   = ($urandom_range(0, 1) == 1);
      ex_redirect  = ($urandom_range(0, 7) == 0);
      ex_is_muldiv = ($urandom_range(0, 5) == 0);
      md_done      = ($urandom_range(0, 3) == 0);
    end

    tick(); idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
